// File: rtl/mux_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package mux_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/muxGL.sv
// Gate-level 8:1 mux: each data bit is ANDed with its decoded select, then ORed.
module muxGL (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       y
);

  logic [2:0] sel_n;
  logic [7:0] term;

  not u_inv0 (sel_n[0], sel[0]);
  not u_inv1 (sel_n[1], sel[1]);
  not u_inv2 (sel_n[2], sel[2]);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_term
      localparam logic [2:0] IDX = 3'(gi);
      and u_and (term[gi], in[gi],
                 IDX[0] ? sel[0] : sel_n[0],
                 IDX[1] ? sel[1] : sel_n[1],
                 IDX[2] ? sel[2] : sel_n[2]);
    end
  endgenerate

  or u_or (y, term[0], term[1], term[2], term[3], term[4], term[5], term[6], term[7]);

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin burst-limited arbiter that steers the owner's data bit through an 8:1 mux.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] in,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               y,
  output logic               y_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t             state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               busy_reg;
  logic [SEL_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [SEL_W-1:0]   search_ptr;
  logic [SEL_W:0]     pick;
  logic               release_now;

  // Returns {found, index} of the first set request at or above p, wrapping 7->0.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   p);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = p + SEL_W'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // On release the search restarts just past the outgoing owner.
  always_comb begin
    search_ptr  = (state_reg == BUSY) ? sel_reg + SEL_W'(1) : ptr_reg;
    pick        = rr_pick(req, search_ptr);
    release_now = (state_reg == BUSY) && (!req[sel_reg] || cnt_reg == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick[SEL_W]) begin
            state_reg <= BUSY;
            sel_reg   <= pick[SEL_W-1:0];
            gnt_reg   <= sel_onehot(pick[SEL_W-1:0]);
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr_reg <= search_ptr;
            cnt_reg <= '0;
            if (pick[SEL_W]) begin
              sel_reg <= pick[SEL_W-1:0];
              gnt_reg <= sel_onehot(pick[SEL_W-1:0]);
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign sel     = sel_reg;
  assign busy    = busy_reg;
  assign y_valid = busy_reg & req[sel_reg];

  muxGL u_mux (
    .in  (in),
    .sel (sel_reg),
    .y   (y)
  );

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench: two arbiters (burst 4 and burst 1) checked against a reference model.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] in;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b, y_a, y_b, yv_a, yv_b;

  always #5 clk = ~clk;

  mux_arbiter #(.BURST_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .in(in),
    .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .y(y_a), .y_valid(yv_a)
  );

  mux_arbiter #(.BURST_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .in(in),
    .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .y(y_b), .y_valid(yv_b)
  );

  typedef struct {
    int         inst;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  int         m_bl[2]  = '{4, 1};
  logic       m_st[2];
  logic [2:0] m_sel[2];
  logic [2:0] m_ptr[2];
  int         m_cnt[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic logic [2:0] search(input logic [7:0] r, input logic [2:0] p);
    for (int i = 0; i < 8; i++)
      if (r[(p + i) % 8]) return 3'((p + i) % 8);
    return p;
  endfunction

  function automatic logic [7:0] exp_gnt(input int k);
    return m_st[k] ? (8'h01 << m_sel[k]) : 8'h00;
  endfunction

  // Reference behaviour evaluated at each rising edge from the inputs seen there.
  task automatic model_edge(input int k);
    if (rst) begin
      m_st[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
    end else if (!m_st[k]) begin
      if (req != 0) begin
        m_sel[k] = search(req, m_ptr[k]); m_cnt[k] = 0; m_st[k] = 1;
      end
    end else if (!req[m_sel[k]] || m_cnt[k] == m_bl[k] - 1) begin
      m_ptr[k] = 3'((m_sel[k] + 1) % 8);
      m_cnt[k] = 0;
      if (req != 0) m_sel[k] = search(req, m_ptr[k]);
      else          m_st[k]  = 0;
    end else begin
      m_cnt[k]++;
    end
  endtask

  task automatic check_comb();
    check_eq("y_a",  y_a,  in[m_sel[0]]);
    check_eq("yv_a", yv_a, m_st[0] & req[m_sel[0]]);
    check_eq("y_b",  y_b,  in[m_sel[1]]);
    check_eq("yv_b", yv_b, m_st[1] & req[m_sel[1]]);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cycle++;
    for (int k = 0; k < 2; k++) begin
      model_edge(k);
      e.inst = k; e.gnt = exp_gnt(k); e.sel = m_sel[k]; e.busy = m_st[k];
      exp_q.push_back(e);
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.inst == 0) begin
        check_eq("gnt_a", gnt_a, e.gnt);
        check_eq("busy_a", busy_a, e.busy);
        if (e.busy) check_eq("sel_a", sel_a, e.sel);
      end else begin
        check_eq("gnt_b", gnt_b, e.gnt);
        check_eq("busy_b", busy_b, e.busy);
        if (e.busy) check_eq("sel_b", sel_b, e.sel);
      end
    end
    check_comb();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [7:0] gnt_hold;
  int         run_len;

  initial begin
    rst = 1'b1; req = 8'h00; in = 8'h00;
    ticks(2);
    check_eq("reset_sel_a", sel_a, 3'd0);
    rst = 1'b0;
    ticks(5);                                   // idle with no requests

    // All requesting: burst-4 rotation and burst-1 alternating data.
    req = 8'hFF; in = 8'b10101010;
    tick();
    check_eq("first_owner_a", sel_a, 3'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("y_alt_b", y_b, logic'(i[0] == 1'b0));
    end
    ticks(30);
    req = 8'h00;
    ticks(3);

    // Single short request: latency 1, release when dropped.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h04; ticks(2);
    req = 8'h00; ticks(3);

    // Sole continuous requester keeps the channel.
    req = 8'h20;
    run_len = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (gnt_a == 8'h20) run_len++;
    end
    check_eq("sole_hold_a", run_len, 13);
    req = 8'h00; ticks(2);

    // Reset during a burst from owner 3, then 3 regains the channel.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h08; ticks(3);
    rst = 1'b1; req = 8'h88; tick();
    check_eq("rst_mid_gnt_a", gnt_a, 8'h00);
    rst = 1'b0; tick();
    check_eq("post_rst_sel_a", sel_a, 3'd3);

    // Random traffic with mid-cycle input changes.
    for (int i = 0; i < 250; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = 8'h00;
      in  = 8'($urandom);
      tick();
      gnt_hold = gnt_a;
      req = 8'($urandom);
      in  = 8'($urandom);
      #1;
      check_eq("between_edges_gnt_a", gnt_a, gnt_hold);
      check_comb();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, maximum consecutive grant cycles per owner; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 8, request from requester i on bit i.
REQ-005 SHALL have port in, input, 8, data bit from requester i on bit i.
REQ-006 SHALL have port gnt, output, 8, one-hot registered grant; all zero when idle.
REQ-007 SHALL have port sel, output, 3, registered index of the current owner; drives the 8:1 mux select.
REQ-008 SHALL have port busy, output, 1, registered; high while an owner holds the channel.
REQ-009 SHALL have port y, output, 1, in[sel] through the 8:1 mux.
REQ-010 SHALL have port y_valid, output, 1, combinational busy AND req[sel].

Function
REQ-011 SHALL keep a 3-bit priority pointer ptr and search req from ptr upward, wrapping 7->0, taking the first set bit as winner.
REQ-012 SHALL implement two states: IDLE (gnt=0, busy=0) and BUSY (gnt one-hot, busy=1).
REQ-013 In IDLE, if any req bit is set at an edge, SHALL load gnt/sel with the winner, enter BUSY and clear burst counter cnt at that edge; grant latency is 1 cycle.
REQ-014 In BUSY, cnt SHALL increment each edge; the owner SHALL be released at the edge where req[sel]=0 or cnt=BURST_LEN-1.
REQ-015 On release SHALL set ptr to sel+1 (mod 8) and re-arbitrate at the same edge with that pointer; if a winner exists, grant it with no idle cycle and clear cnt, else enter IDLE.
REQ-016 A sole continuous requester SHALL be re-granted at every release (pointer wraps back to it), with cnt restarting at 0.
REQ-017 Requests from non-owners SHALL NOT pre-empt the owner before release.
REQ-018 With BURST_LEN=1 every edge in BUSY SHALL be a release, rotating ownership every cycle among active requesters.
REQ-019 gnt SHALL always equal the one-hot decode of sel while busy=1, and be zero while busy=0.
REQ-020 y SHALL follow in[sel] combinationally in every state; consumers qualify it with y_valid.
REQ-021 Changes on req or in between edges SHALL NOT alter gnt, sel, busy or ptr.

Reset
REQ-022 When rst=1 at an edge: state=IDLE, gnt=0, sel=0, busy=0, ptr=0, cnt=0; y_valid therefore 0.
REQ-023 rst SHALL override every other event, including a release or grant at the same edge and a burst in progress.
REQ-024 The first arbitration after reset SHALL start its search at requester 0.

Structure
REQ-025 Shared package SHALL hold NUM_REQ=8, SEL_W=3, CNT_W=4 and the state encoding IDLE=0, BUSY=1.
REQ-026 The data path SHALL instantiate the team's existing gate-level 8:1 mux, muxGL, with in, sel and y; the arbiter adds no other data logic.
REQ-027 Round-robin winner search SHALL be a purely combinational function of req and ptr inside mux_arbiter; no further sub-module.

Verification
REQ-028 Reset then req=8'h00 for 5 cycles -> gnt=0, busy=0, y_valid=0 throughout.
REQ-029 req=8'hFF held, BURST_LEN=4 -> sel sequence 0,1,...,7,0, each owner exactly 4 cycles, no idle gap.
REQ-030 req=8'h04 for 2 cycles then 8'h00 -> gnt=8'h04 one cycle after assertion, released when req drops, busy=0 the cycle after.
REQ-031 req=8'h20 held alone, BURST_LEN=4 -> gnt stays 8'h20 continuously, cnt restarts every 4 cycles.
REQ-032 Owner 3 mid-burst (cnt=2), rst=1 for 1 cycle with req=8'h88 -> all outputs 0, then first grant goes to requester 3.
REQ-033 in=8'b10101010, req=8'hFF, BURST_LEN=1 -> y sequence 0,1,0,1,0,1,0,1 with y_valid=1 every cycle.
